// File: rtl/zhang_cnn_mac_pipe.sv
// zhang_cnn_mac_pipe: pipelined signed multiply-accumulate engine with
// requantization (rounding right shift + signed saturation) and a
// valid/ready output that backpressures the whole pipeline.
//
// Ports:
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   cfg_acc_en              1 = accumulate until in_last, 0 = bypass (per beat)
//   in_valid / in_ready     input handshake (in_ready is combinational)
//   din0, din1              signed operands
//   in_last                 closes an accumulation group
//   in_shift                requant shift, taken from the group-closing beat
//   out_valid / out_ready   output handshake
//   out_data, out_sat       requantized result and its clip flag
module zhang_cnn_mac_pipe #(
    parameter int unsigned DIN0_WIDTH  = 16,
    parameter int unsigned DIN1_WIDTH  = 16,
    parameter int unsigned MUL_STAGES  = 2,
    parameter int unsigned ACC_WIDTH   = 40,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT_WIDTH = 6
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          cfg_acc_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DIN0_WIDTH-1:0]  din0,
    input  logic signed [DIN1_WIDTH-1:0]  din1,
    input  logic                          in_last,
    input  logic        [SHIFT_WIDTH-1:0] in_shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_sat
);

    localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int unsigned RW = ACC_WIDTH + 1;
    localparam int unsigned LS = MUL_STAGES - 1;

    logic stall;

    logic signed [PW-1:0]          prod_c;
    logic signed [PW-1:0]          m_prod  [MUL_STAGES];
    logic        [SHIFT_WIDTH-1:0] m_shift [MUL_STAGES];
    logic        [MUL_STAGES-1:0]  m_valid;
    logic        [MUL_STAGES-1:0]  m_close;

    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   sum_c;
    logic signed [ACC_WIDTH-1:0]   sum_q;
    logic        [SHIFT_WIDTH-1:0] sum_shift_q;
    logic                          sum_valid_q;

    logic signed [RW-1:0]          sum_ext_c;
    logic signed [RW-1:0]          rnd_c;
    logic signed [RW-1:0]          r_c;
    logic                          pos_ovf_c;
    logic                          neg_ovf_c;
    logic signed [OUT_WIDTH-1:0]   q_c;

    // A held result freezes every stage, accumulator included.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign prod_c = PW'(din0) * PW'(din1);

    // Multiplier pipeline; close flag and shift ride along with the product.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < int'(MUL_STAGES); i++) begin
                m_prod[i]  <= '0;
                m_shift[i] <= '0;
            end
            m_valid <= '0;
            m_close <= '0;
        end else if (!stall) begin
            m_prod[0]  <= prod_c;
            m_shift[0] <= in_shift;
            m_valid[0] <= in_valid;
            m_close[0] <= in_last || !cfg_acc_en;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                m_prod[i]  <= m_prod[i-1];
                m_shift[i] <= m_shift[i-1];
                m_valid[i] <= m_valid[i-1];
                m_close[i] <= m_close[i-1];
            end
        end
    end

    // Wraps modulo 2^ACC_WIDTH by construction.
    assign sum_c = acc_q + ACC_WIDTH'(m_prod[LS]);

    // Accumulate stage: a closing beat forwards its sum and clears acc.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_q       <= '0;
            sum_q       <= '0;
            sum_shift_q <= '0;
            sum_valid_q <= 1'b0;
        end else if (!stall) begin
            sum_valid_q <= m_valid[LS] && m_close[LS];
            if (m_valid[LS]) begin
                if (m_close[LS]) begin
                    sum_q       <= sum_c;
                    sum_shift_q <= m_shift[LS];
                    acc_q       <= '0;
                end else begin
                    acc_q <= sum_c;
                end
            end
        end
    end

    // Rounding shift in one extra bit so the rounding add cannot overflow.
    always_comb begin
        sum_ext_c = RW'(sum_q);
        rnd_c     = '0;
        r_c       = sum_ext_c;
        if (sum_shift_q == '0) begin
            r_c = sum_ext_c;
        end else if (32'(sum_shift_q) >= ACC_WIDTH) begin
            r_c = sum_q[ACC_WIDTH-1] ? '1 : '0;
        end else begin
            rnd_c = sum_ext_c + (RW'(1) << (sum_shift_q - SHIFT_WIDTH'(1)));
            r_c   = rnd_c >>> sum_shift_q;
        end
    end

    // Out of range when the bits above the output sign bit are not a pure sign extension.
    always_comb begin
        pos_ovf_c = !r_c[RW-1] && (|r_c[RW-2:OUT_WIDTH-1]);
        neg_ovf_c = r_c[RW-1] && !(&r_c[RW-2:OUT_WIDTH-1]);
        q_c       = r_c[OUT_WIDTH-1:0];
        if (pos_ovf_c) begin
            q_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (neg_ovf_c) begin
            q_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    // Output register; a bubble loads zeros once the current result is taken.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            out_valid <= sum_valid_q;
            out_data  <= sum_valid_q ? q_c : '0;
            out_sat   <= sum_valid_q && (pos_ovf_c || neg_ovf_c);
        end
    end

endmodule

// File: tb/tb_zhang_cnn_mac_pipe.sv
// Self-checking bench for zhang_cnn_mac_pipe with default parameters.
module tb_zhang_cnn_mac_pipe;

    localparam int ACC_W = 40;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic               cfg_acc_en = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] din0 = '0;
    logic signed [15:0] din1 = '0;
    logic               in_last = 1'b0;
    logic        [5:0]  in_shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic               out_sat;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic               acc;
        logic               last;
        logic        [5:0]  sh;
    } beat_t;

    beat_t beats[$];
    int    exp_d[$];
    bit    exp_s[$];
    int    got_d[$];
    bit    got_s[$];
    int    stable_bad;
    int    ready_bad;

    zhang_cnn_mac_pipe dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .cfg_acc_en (cfg_acc_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din0       (din0),
        .din1       (din1),
        .in_last    (in_last),
        .in_shift   (in_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat)
    );

    always #5 ap_clk = ~ap_clk;

    // Requantization reference: rounding shift then clamp to 16-bit signed.
    function automatic void requant(input longint sum, input int sh, output int d, output bit s);
        longint r;
        if (sh == 0) r = sum;
        else if (sh >= ACC_W) r = (sum < 0) ? -1 : 0;
        else r = (sum + (longint'(1) << (sh - 1))) >>> sh;
        s = 1'b1;
        if (r > 32767) d = 32767;
        else if (r < -32768) d = -32768;
        else begin d = int'(r); s = 1'b0; end
    endfunction

    // Group-level reference: walk the beat list, emit one result per closed group.
    function automatic void build_expected();
        longint acc = 0;
        int d;
        bit s;
        exp_d = {};
        exp_s = {};
        foreach (beats[i]) begin
            acc += longint'(beats[i].a) * longint'(beats[i].b);
            if (!beats[i].acc || beats[i].last) begin
                requant(acc, int'(beats[i].sh), d, s);
                exp_d.push_back(d);
                exp_s.push_back(s);
                acc = 0;
            end
        end
    endfunction

    function automatic beat_t mk(input int a, input int b, input bit acc, input bit last, input int sh);
        beat_t t;
        t.a = 16'(a); t.b = 16'(b); t.acc = acc; t.last = last; t.sh = 6'(sh);
        return t;
    endfunction

    // Presents the queued beats in order, each held until accepted.
    task automatic drive_beats(input int budget);
        int i = 0;
        int cyc = 0;
        while (i < beats.size() && cyc < budget) begin
            @(posedge ap_clk); #1;
            in_valid   = 1'b1;
            din0       = beats[i].a;
            din1       = beats[i].b;
            cfg_acc_en = beats[i].acc;
            in_last    = beats[i].last;
            in_shift   = beats[i].sh;
            @(negedge ap_clk);
            if (in_ready) i++;
            cyc++;
        end
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (i != beats.size()) begin
            fails++;
            $display("FAIL drive_timeout: accepted %0d beats, required %0d", i, beats.size());
        end
    endtask

    // Gathers results; mode 0 ready always, 1 = 5 stalled cycles then random, 2 random.
    task automatic collect(input int n, input int mode, input int budget);
        int cyc = 0;
        bit held = 1'b0;
        logic signed [15:0] hd = '0;
        logic hs = 1'b0;
        got_d = {};
        got_s = {};
        stable_bad = 0;
        ready_bad = 0;
        while (got_d.size() < n && cyc < budget) begin
            @(posedge ap_clk); #1;
            cyc++;
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc <= 5) ? 1'b0 : 1'($urandom_range(0, 1));
            else out_ready = 1'($urandom_range(0, 1));
            @(negedge ap_clk);
            if (held && (!out_valid || out_data !== hd || out_sat !== hs)) stable_bad++;
            held = 1'b0;
            if (out_valid && !out_ready) begin
                if (in_ready !== 1'b0) ready_bad++;
                held = 1'b1;
                hd = out_data;
                hs = out_sat;
            end
            if (out_valid && out_ready) begin
                got_d.push_back(int'(out_data));
                got_s.push_back(out_sat);
            end
        end
        @(posedge ap_clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if (out_data !== 16'sd0) begin fails++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
        checks++;
        if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat: got %b required 0", out_sat); end
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_bypass_latency();
        int lat;
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b1; cfg_acc_en = 1'b0; in_last = 1'b0;
        din0 = -16'sd3; din1 = 16'sd7; in_shift = '0;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        checks++;
        if (lat != 4) begin fails++; $display("FAIL bypass_latency: got %0d cycles required 4", lat); end
        checks++;
        if (out_data !== -16'sd21) begin fails++; $display("FAIL bypass_data: got %0d required -21", out_data); end
        checks++;
        if (out_sat !== 1'b0) begin fails++; $display("FAIL bypass_sat: got %b required 0", out_sat); end
        @(posedge ap_clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bypass_single_result: got out_valid %b required 0", out_valid); end
    endtask

    task automatic test_accumulate();
        beats = {};
        for (int i = 0; i < 4; i++) beats.push_back(mk(100, 100, 1'b1, i == 3, 4));
        fork
            drive_beats(100);
            collect(1, 0, 100);
        join
        repeat (6) @(posedge ap_clk);
        #1;
        checks++;
        if (got_d.size() != 1) begin fails++; $display("FAIL acc_count: got %0d results required 1", got_d.size()); end
        else begin
            checks++;
            if (got_d[0] != 2500 || got_s[0] != 1'b0)
                begin fails++; $display("FAIL acc_value: got %0d sat %b required 2500 sat 0", got_d[0], got_s[0]); end
        end
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL acc_extra_output: got out_valid %b required 0", out_valid); end
    endtask

    task automatic test_saturation();
        beats = {};
        beats.push_back(mk(-32768, -32768, 1'b0, 1'b0, 0));
        beats.push_back(mk(32767, -32768, 1'b0, 1'b0, 0));
        fork
            drive_beats(100);
            collect(2, 0, 100);
        join
        checks++;
        if (got_d.size() != 2) begin fails++; $display("FAIL sat_count: got %0d required 2", got_d.size()); end
        else begin
            checks++;
            if (got_d[0] != 32767 || got_s[0] != 1'b1)
                begin fails++; $display("FAIL sat_pos: got %0d sat %b required 32767 sat 1", got_d[0], got_s[0]); end
            checks++;
            if (got_d[1] != -32768 || got_s[1] != 1'b1)
                begin fails++; $display("FAIL sat_neg: got %0d sat %b required -32768 sat 1", got_d[1], got_s[1]); end
        end
    endtask

    task automatic test_rounding();
        int req[4] = '{-1, 2, 1, 0};
        beats = {};
        beats.push_back(mk(-4, 6, 1'b1, 1'b1, 4));
        beats.push_back(mk(4, 6, 1'b1, 1'b1, 4));
        beats.push_back(mk(23, 1, 1'b1, 1'b1, 4));
        beats.push_back(mk(-8, 1, 1'b1, 1'b1, 4));
        fork
            drive_beats(100);
            collect(4, 0, 100);
        join
        checks++;
        if (got_d.size() != 4) begin fails++; $display("FAIL round_count: got %0d required 4", got_d.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_d[i] != req[i] || got_s[i] != 1'b0)
                    begin fails++; $display("FAIL round_%0d: got %0d sat %b required %0d sat 0", i, got_d[i], got_s[i], req[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        beats = {};
        for (int i = 0; i < 8; i++) beats.push_back(mk(int'($urandom_range(0, 65535)) - 32768,
                                                       int'($urandom_range(0, 65535)) - 32768,
                                                       1'b0, 1'($urandom_range(0, 1)), 0));
        build_expected();
        out_ready = 1'b0;
        fork
            drive_beats(500);
            collect(8, 1, 500);
        join
        checks++;
        if (got_d.size() != 8) begin fails++; $display("FAIL bp_count: got %0d required 8", got_d.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_d[i] != exp_d[i] || got_s[i] != exp_s[i])
                    begin fails++; $display("FAIL bp_result_%0d: got %0d sat %b required %0d sat %b", i, got_d[i], got_s[i], exp_d[i], exp_s[i]); end
            end
        end
        checks++;
        if (stable_bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable stalled cycles required 0", stable_bad); end
        checks++;
        if (ready_bad != 0) begin fails++; $display("FAIL bp_in_ready: got %0d stalled cycles with in_ready=1 required 0", ready_bad); end
        repeat (4) @(posedge ap_clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_duplicate: got out_valid %b required 0", out_valid); end
    endtask

    task automatic test_reset_mid_group();
        out_ready = 1'b0;
        @(posedge ap_clk); #1;
        in_valid = 1'b1; cfg_acc_en = 1'b0; in_last = 1'b0; din0 = 16'sd1; din1 = 16'sd1; in_shift = '0;
        @(posedge ap_clk); #1;
        cfg_acc_en = 1'b1; din0 = 16'sd5; din1 = 16'sd5;
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        @(posedge ap_clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid: got %b required 1", out_valid); end
        #1;
        ap_rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b required 0", out_valid); end
        checks++;
        if (out_data !== 16'sd0) begin fails++; $display("FAIL rst_async_data: got %0d required 0", out_data); end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        out_ready = 1'b1;
        beats = {};
        beats.push_back(mk(2, 3, 1'b1, 1'b1, 0));
        fork
            drive_beats(100);
            collect(1, 0, 100);
        join
        checks++;
        if (got_d.size() != 1) begin fails++; $display("FAIL rst_after_count: got %0d required 1", got_d.size()); end
        else begin
            checks++;
            if (got_d[0] != 6) begin fails++; $display("FAIL rst_after_value: got %0d required 6", got_d[0]); end
        end
    endtask

    task automatic test_random();
        int n_groups = 40;
        beats = {};
        for (int g = 0; g < n_groups; g++) begin
            bit acc = ($urandom_range(0, 3) != 0);
            int len = acc ? int'($urandom_range(1, 6)) : 1;
            int sh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 20));
            for (int k = 0; k < len; k++)
                beats.push_back(mk(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                                   acc, acc ? (k == len - 1) : 1'($urandom_range(0, 1)), sh));
        end
        build_expected();
        fork
            drive_beats(4000);
            collect(exp_d.size(), 2, 4000);
        join
        checks++;
        if (got_d.size() != exp_d.size()) begin fails++; $display("FAIL rand_count: got %0d required %0d", got_d.size(), exp_d.size()); end
        else begin
            foreach (exp_d[i]) begin
                checks++;
                if (got_d[i] != exp_d[i] || got_s[i] != exp_s[i])
                    begin fails++; $display("FAIL rand_result_%0d: got %0d sat %b required %0d sat %b", i, got_d[i], got_s[i], exp_d[i], exp_s[i]); end
            end
        end
        checks++;
        if (stable_bad != 0 || ready_bad != 0)
            begin fails++; $display("FAIL rand_stall: got %0d unstable and %0d in_ready errors required 0", stable_bad, ready_bad); end
    endtask

    initial begin
        test_reset();
        test_bypass_latency();
        test_accumulate();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_reset_mid_group();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/zhang_cnn_mac_pipe.md
Name: zhang_cnn_mac_pipe

Overview:
- Pipelined signed multiply-accumulate engine for the quantized convolution datapath; successor to the single-cycle 16s x 16s -> 32 multiplier.
- Operand widths and multiplier pipeline depth are parametrised.
- Accumulates products over a kernel window delimited by a last flag, or passes each product through in bypass mode.
- Requantizes each result (rounding right shift, then signed saturation) and presents it on a valid/ready output with full-pipeline backpressure.

Parameters:
DIN0_WIDTH, 16, signed width of din0 (activation)
DIN1_WIDTH, 16, signed width of din1 (weight)
MUL_STAGES, 2, register stages in the multiplier, legal 1..4
ACC_WIDTH, 40, signed accumulator width, must be >= DIN0_WIDTH+DIN1_WIDTH
OUT_WIDTH, 16, signed width of the requantized output
SHIFT_WIDTH, 6, width of the requantization shift amount

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst  in  1  asynchronous active-high reset
cfg_acc_en  in  1  1 = accumulate until in_last; 0 = bypass, every beat is its own group
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
din0  in  DIN0_WIDTH  signed operand
din1  in  DIN1_WIDTH  signed operand
in_last  in  1  final beat of the accumulation group (ignored when cfg_acc_en=0)
in_shift  in  SHIFT_WIDTH  requant shift, sampled on a group-closing beat
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  OUT_WIDTH  requantized signed result
out_sat  out  1  out_data was clipped

Behaviour:
- Reset (asynchronous assert, released on a clock edge): all pipeline valids = 0, accumulator = 0, out_valid = 0, out_data = 0, out_sat = 0. Reset mid-group discards the partial sum and every in-flight beat.
- stall = out_valid && !out_ready. in_ready = !stall (combinational). While stall = 1, every pipeline register, including the accumulator, holds its value.
- Stage M1..M_MUL_STAGES:
  - product = din0 * din1, full precision signed, DIN0_WIDTH+DIN1_WIDTH bits.
  - valid, close flag (in_last || !cfg_acc_en) and in_shift travel alongside the product.
  - cfg_acc_en is sampled per beat.
- Accumulate stage, on a valid beat:
  - sum = acc + sign-extended product, computed in ACC_WIDTH bits; wraps modulo 2^ACC_WIDTH with no overflow detection.
  - If close = 0: acc <= sum.
  - If close = 1: sum is forwarded to the requant stage with its shift, and acc <= 0 in the same cycle.
  - Bubbles leave acc unchanged.
- Requant stage, registered output:
  - If shift = 0: r = sum.
  - If shift > 0: r = (sum + 2^(shift-1)) >>> shift, computed in ACC_WIDTH+1 bits (round half toward +inf).
  - Shifts >= ACC_WIDTH give 0 or -1 by sign.
  - If r > 2^(OUT_WIDTH-1)-1: out_data = max, out_sat = 1.
  - If r < -2^(OUT_WIDTH-1): out_data = min, out_sat = 1.
  - Otherwise out_data = r, out_sat = 0.
- out_valid rules:
  - out_valid rises when a closed group reaches the output register.
  - out_data and out_sat stay stable until the handshake completes.
  - On out_valid && out_ready, the next result (or 0 on a bubble) loads in that same cycle.
- Latency: a closing beat accepted at cycle t yields out_valid at t+MUL_STAGES+2 when there is no stall.
- Throughput: one beat per cycle; back-to-back groups need no idle cycles.
- A beat with in_last=1 in a one-beat group outputs that product alone.
- in_last is ignored when cfg_acc_en=0; the bypass beat still clears acc, so switching mode mid-group discards the partial sum.
- Output order always equals input order.

Test Plan:
- Bypass, MUL_STAGES=2, shift 0: din0=-3, din1=7, one beat -> out_data=-21, out_sat=0, out_valid exactly 4 cycles after acceptance.
- Accumulate: 4 beats of 100*100, in_last on the 4th, shift 4 -> single result 2500 ((40000+8)>>>4), no intermediate out_valid.
- Saturation, shift 0:
  - -32768*-32768 -> 32767, out_sat=1.
  - 32767*-32768 -> -32768, out_sat=1.
- Rounding, shift 4, one-beat groups:
  - sums -24 -> -1.
  - sums 24 -> 2.
  - sums 23 -> 1.
  - sums -8 -> 0.
- Backpressure: 8 back-to-back bypass beats with out_ready=0 for 5 cycles, then random -> all 8 products delivered in order. While stalled: in_ready=0 and out_data stable; no loss or duplication.
- Reset mid-group: accept 2 of 4 beats (5*5), pulse ap_rst asynchronously -> out_valid=0 at once. Then a one-beat group 2*3 -> out_data=6, with no residue from the aborted group.
